dmem_stall_ctrl: RTL and testbench
==================================

// Module: dmem_stall_ctrl
// PURPOSE
// Sequences data-memory accesses for the MEM stage against a variable-latency
// req/ack data memory. While an access is outstanding it freezes PC, IF/ID,
// ID/EX and EX/MEM, and injects bubbles into MEM/WB (wb_bubble gates the
// memtoreg/regwrite inputs of the MEM/WB register). Load data is held for MEM/WB
// capture. Hung accesses are bounded by a timeout with a sticky error flag.
// PARAMETERS
// TIMEOUT  15  max WAIT cycles without dmem_ack before abort (1..2**CW-1)
// CW       4   width of the wait counter
// PORTS
// clk            in   1   pipeline clock; all state updates on posedge
// reset          in   1   synchronous, active-high
// mem_read_in    in   1   EX/MEM memread of the instruction in MEM
// mem_write_in   in   1   EX/MEM memwrite of the instruction in MEM
// addr_in        in   32  EX/MEM ALU result (byte address)
// wdata_in       in   32  EX/MEM store data
// dmem_req       out  1   request to data memory (registered)
// dmem_we        out  1   1=write, 0=read; valid while dmem_req
// dmem_addr      out  32  latched address; valid while dmem_req
// dmem_wdata     out  32  latched store data; valid while dmem_req
// dmem_ack       in   1   memory completion; sampled only in WAIT
// dmem_rdata     in   32  read data; valid in cycle dmem_ack=1
// stall          out  1   freeze PC, IF/ID, ID/EX, EX/MEM
// wb_bubble      out  1   force MEM/WB regwrite/memtoreg inputs to 0
// read_data_out  out  32  load data toward MEM/WB read_data_in
// bus_err        out  1   sticky: an access timed out
// BEHAVIOUR
// - Reset: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0,
//   read_data_out=0, bus_err=0, counter=0; stall=wb_bubble=0 follow from IDLE.
// - FSM states: IDLE, WAIT, DONE.
// - IDLE: acc = mem_read_in|mem_write_in. If acc: stall=1, wb_bubble=1; at edge
//   latch addr/wdata, dmem_we<=mem_write_in & ~mem_read_in (both set => read),
//   dmem_req<=1, counter<=0, ->WAIT. If !acc: stall=0, stay.
// - WAIT: stall=1, wb_bubble=1, dmem_req=1 with addr/we/wdata held stable.
//   dmem_ack=1: read_data_out<=dmem_we ? 32'b0 : dmem_rdata, dmem_req<=0,
//   ->DONE. Else if counter==TIMEOUT-1: bus_err<=1, read_data_out<=0,
//   dmem_req<=0, ->DONE. Else counter<=counter+1 (never wraps).
// - DONE: stall=0, wb_bubble=0; EX/MEM and MEM/WB advance at this edge, MEM/WB
//   captures read_data_out. Unconditional ->IDLE; mem_read/write_in are not
//   sampled in DONE (same instruction still present).
// - stall and wb_bubble are combinational from state and inputs; every other
//   output is registered.
// - Latency: min 3 cycles per access (IDLE-detect, WAIT with ack, DONE), i.e.
//   2 stall cycles; each extra ack-less WAIT cycle adds one stall cycle.
// - Back-to-back accesses: a new access is detected in the IDLE cycle after DONE.
// - dmem_ack outside WAIT is ignored. bus_err clears only on reset.
// - Reset mid-access (any state): return to reset values at the next edge; the
//   outstanding request is dropped with no further handshake.
// TESTING
// 1 Load, ack in 1st WAIT, rdata=32'hDEADBEEF -> stall high 2 cycles,
//   read_data_out=DEADBEEF in DONE, dmem_req high exactly 1 cycle.
// 2 Store addr=32'h40 wdata=32'h1234, ack after 3 WAIT cycles -> dmem_we=1,
//   addr/wdata stable for 4 req cycles, stall 5 cycles, read_data_out=0.
// 3 No ack, TIMEOUT=15 -> dmem_req drops after 15 WAIT cycles, bus_err=1
//   sticky, DONE reached, next load completes normally with bus_err still 1.
// 4 Two loads back-to-back with immediate ack -> two 3-cycle sequences, IDLE
//   in between, each result correct in its DONE cycle.
// 5 reset asserted in WAIT -> next edge: dmem_req=0, stall=0, all outputs 0;
//   later ack pulse ignored.
// 6 mem_read_in=mem_write_in=1 -> treated as read (dmem_we=0); stray ack in
//   IDLE -> no effect.

Source files
------------

// File: rtl/dmem_stall_ctrl.sv
// dmem_stall_ctrl: MEM-stage sequencer for a variable-latency req/ack data memory with pipeline stall and timeout
module dmem_stall_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int CW = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] wdata_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        wb_bubble,
  output logic [31:0] read_data_out,
  output logic        bus_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic acc;
  assign acc = mem_read_in | mem_write_in;
  assign stall = (state == IDLE && acc) || state == WAIT;
  assign wb_bubble = stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_wdata <= '0;
      read_data_out <= '0;
      bus_err <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (acc) begin
          dmem_addr <= addr_in;
          dmem_wdata <= wdata_in;
          dmem_we <= mem_write_in & ~mem_read_in;
          dmem_req <= 1'b1;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: if (dmem_ack) begin
          read_data_out <= dmem_we ? '0 : dmem_rdata;
          dmem_req <= 1'b0;
          state <= DONE;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          bus_err <= 1'b1;
          read_data_out <= '0;
          dmem_req <= 1'b0;
          state <= DONE;
        end else begin
          cnt <= cnt + CW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_stall_ctrl.sv
// tb_dmem_stall_ctrl: table-driven and randomized transaction-level checks of dmem_stall_ctrl
module tb_dmem_stall_ctrl;
  localparam int TO = 15;
  logic clk, reset, mem_read_in, mem_write_in, dmem_ack;
  logic [31:0] addr_in, wdata_in, dmem_rdata;
  logic dmem_req, dmem_we, stall, wb_bubble, bus_err;
  logic [31:0] dmem_addr, dmem_wdata, read_data_out;
  int checks = 0, errors = 0;
  logic err_m = 1'b0;
  logic [31:0] rdo_m = '0;

  dmem_stall_ctrl #(.TIMEOUT(TO), .CW(4)) dut (
    .clk(clk), .reset(reset), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .addr_in(addr_in), .wdata_in(wdata_in), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .wb_bubble(wb_bubble),
    .read_data_out(read_data_out), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic rd, wr;
    logic [31:0] a, d;
    int delay;
    logic [31:0] rdata;
    logic we;
    logic [31:0] rdo;
    logic err;
  } vec_t;
  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      mem_read_in = 1'b0;
      mem_write_in = 1'b0;
      addr_in = $urandom;
      wdata_in = $urandom;
      dmem_ack = 1'($urandom);
      dmem_rdata = $urandom;
      @(negedge clk);
      chk("idle_stall", 32'(stall), 32'd0);
      chk("idle_req", 32'(dmem_req), 32'd0);
      chk("idle_rdo", read_data_out, rdo_m);
      chk("idle_err", 32'(bus_err), 32'(err_m));
      tick();
    end
  endtask

  // one whole access: detect cycle, WAIT cycles until ack or timeout, DONE
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                         input int delay, input logic [31:0] rdv, input logic exp_we,
                         input logic [31:0] exp_rdo, input logic exp_err);
    int n;
    n = (delay < TO) ? delay + 1 : TO;
    mem_read_in = rd;
    mem_write_in = wr;
    addr_in = a;
    wdata_in = d;
    dmem_ack = 1'($urandom);
    dmem_rdata = $urandom;
    @(negedge clk);
    chk("det_stall", 32'(stall), 32'd1);
    chk("det_bubble", 32'(wb_bubble), 32'd1);
    chk("det_req", 32'(dmem_req), 32'd0);
    tick();
    for (int i = 0; i < n; i++) begin
      dmem_ack = (i == delay);
      dmem_rdata = (i == delay) ? rdv : $urandom;
      addr_in = $urandom;
      wdata_in = $urandom;
      @(negedge clk);
      chk("wait_req", 32'(dmem_req), 32'd1);
      chk("wait_we", 32'(dmem_we), 32'(exp_we));
      chk("wait_addr", dmem_addr, a);
      chk("wait_wdata", dmem_wdata, d);
      chk("wait_stall", 32'(stall), 32'd1);
      chk("wait_bubble", 32'(wb_bubble), 32'd1);
      chk("wait_err", 32'(bus_err), 32'(err_m));
      tick();
    end
    addr_in = a;
    wdata_in = d;
    dmem_ack = 1'($urandom);
    dmem_rdata = $urandom;
    @(negedge clk);
    chk("done_stall", 32'(stall), 32'd0);
    chk("done_bubble", 32'(wb_bubble), 32'd0);
    chk("done_req", 32'(dmem_req), 32'd0);
    chk("done_rdo", read_data_out, exp_rdo);
    chk("done_err", 32'(bus_err), 32'(exp_err));
    err_m = exp_err;
    rdo_m = exp_rdo;
    tick();
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 32'h40, 32'h1234, 3, 32'hA5A5A5A5, 1'b1, 32'h0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 32'h200, 32'h77, 1, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 32'h300, 32'h0, 14, 32'h0BADCAFE, 1'b0, 32'h0BADCAFE, 1'b0};
    tbl[4] = '{1'b1, 1'b0, 32'h400, 32'h0, 99, 32'h11111111, 1'b0, 32'h0, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 32'h500, 32'h0, 2, 32'h12345678, 1'b0, 32'h12345678, 1'b1};
    reset = 1'b1;
    mem_read_in = 1'b0;
    mem_write_in = 1'b0;
    addr_in = '0;
    wdata_in = '0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    tick();
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_rdo", read_data_out, 32'd0);
    chk("rst_err", 32'(bus_err), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick();
    reset = 1'b0;
    idle(3);
    foreach (tbl[k]) begin
      run_txn(tbl[k].rd, tbl[k].wr, tbl[k].a, tbl[k].d, tbl[k].delay, tbl[k].rdata,
              tbl[k].we, tbl[k].rdo, tbl[k].err);
      idle(1);
    end
    run_txn(1'b1, 1'b0, 32'h600, 32'h0, 0, 32'hAAAA0001, 1'b0, 32'hAAAA0001, 1'b1);
    run_txn(1'b1, 1'b0, 32'h604, 32'h0, 0, 32'hBBBB0002, 1'b0, 32'hBBBB0002, 1'b1);
    idle(2);
    for (int t = 0; t < 40; t++) begin
      logic rd, wr, we, e;
      logic [31:0] a, d, rv, ro;
      int dl;
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      a = $urandom;
      d = $urandom;
      rv = $urandom;
      dl = $urandom_range(0, 17);
      we = wr && !rd;
      e = err_m || (dl >= TO);
      ro = (dl >= TO || we) ? 32'h0 : rv;
      run_txn(rd, wr, a, d, dl, rv, we, ro, e);
      idle($urandom_range(0, 2));
    end
    mem_read_in = 1'b1;
    addr_in = 32'h700;
    dmem_ack = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    mem_read_in = 1'b0;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_req", 32'(dmem_req), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    chk("mid_rst_addr", dmem_addr, 32'd0);
    chk("mid_rst_rdo", read_data_out, 32'd0);
    chk("mid_rst_err", 32'(bus_err), 32'd0);
    err_m = 1'b0;
    rdo_m = '0;
    tick();
    dmem_ack = 1'b1;
    dmem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk("stray_ack_req", 32'(dmem_req), 32'd0);
    tick();
    dmem_ack = 1'b0;
    @(negedge clk);
    chk("stray_ack_rdo", read_data_out, 32'd0);
    chk("stray_ack_stall", 32'(stall), 32'd0);
    tick();
    run_txn(1'b1, 1'b0, 32'h800, 32'h0, 1, 32'h5A5A5A5A, 1'b0, 32'h5A5A5A5A, 1'b0);
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
